// File: rtl/button_reader_pkg.sv
// Shared definitions for the pushbutton reader: FSM encoding, default timing
// constants and a counter-width helper.
package button_reader_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int DEB_CYC_DEF  = 16;
    localparam int LONG_CYC_DEF = 256;

    // Bits needed for a counter that must be able to hold max_val itself.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_reader_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin input, reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_reader.sv
// Synchronises and debounces a raw pushbutton into level, press/release/long
// pulses and a wrapping press counter. Long press: BUTTON_READER_LONG_PRESS_EN.
module button_reader
    import button_reader_pkg::*;
#(
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int LONG_CYC = LONG_CYC_DEF,
    parameter int CNT_W    = 8
) (
    input  logic             clk_in1,
    input  logic             rst_in1,
    input  logic             btn_in1,
    output logic             level_out1,
    output logic             press_out1,
    output logic             release_out1,
    output logic             long_out1,
    output logic [CNT_W-1:0] count_out1
);

    localparam int DEB_W = cnt_width(DEB_CYC);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

    logic             sync;
    state_t           state_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic [DEB_W-1:0] deb_cnt_d;
    logic             level_q;
    logic             press_q;
    logic             release_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    sync_2ff u_sync (
        .clk_i (clk_in1),
        .rst_i (rst_in1),
        .d_i   (btn_in1),
        .q_o   (sync)
    );

    assign deb_cnt_d = deb_cnt_q + DEB_W'(1);
    assign count_d   = count_q + CNT_W'(1);

    // A bounce back during a wait state returns to the old stable state silently.
    always_ff @(posedge clk_in1 or posedge rst_in1) begin
        if (rst_in1) begin
            state_q   <= IDLE;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= '0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync) begin
                        state_q   <= PRESS_WAIT;
                        deb_cnt_q <= DEB_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!sync) begin
                        state_q   <= IDLE;
                        deb_cnt_q <= '0;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q   <= PRESSED;
                        deb_cnt_q <= '0;
                        press_q   <= 1'b1;
                        level_q   <= 1'b1;
                        count_q   <= count_d;
                    end else begin
                        deb_cnt_q <= deb_cnt_d;
                    end
                end
                PRESSED: begin
                    if (!sync) begin
                        state_q   <= RELEASE_WAIT;
                        deb_cnt_q <= DEB_W'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (sync) begin
                        state_q   <= PRESSED;
                        deb_cnt_q <= '0;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q   <= IDLE;
                        deb_cnt_q <= '0;
                        release_q <= 1'b1;
                        level_q   <= 1'b0;
                    end else begin
                        deb_cnt_q <= deb_cnt_d;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    deb_cnt_q <= '0;
                end
            endcase
        end
    end

`ifdef BUTTON_READER_LONG_PRESS_EN
    localparam int LONG_W = cnt_width(LONG_CYC);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYC);

    logic [LONG_W-1:0] long_cnt_q;
    logic [LONG_W-1:0] long_cnt_d;
    logic              long_q;

    assign long_cnt_d = long_cnt_q + LONG_W'(1);

    // Saturating at LONG_CYC is what keeps the pulse from repeating.
    always_ff @(posedge clk_in1 or posedge rst_in1) begin
        if (rst_in1) begin
            long_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (state_q == PRESSED && sync) begin
                if (long_cnt_q == LONG_LAST) begin
                    long_q     <= 1'b1;
                    long_cnt_q <= LONG_MAX;
                end else if (long_cnt_q != LONG_MAX) begin
                    long_cnt_q <= long_cnt_d;
                end
            end else if (state_q == RELEASE_WAIT && !sync && deb_cnt_q == DEB_LAST) begin
                long_cnt_q <= '0;
            end
        end
    end

    assign long_out1 = long_q;
`else
    assign long_out1 = 1'b0;
`endif

    assign level_out1   = level_q;
    assign press_out1   = press_q;
    assign release_out1 = release_q;
    assign count_out1   = count_q;

endmodule

// File: tb/tb_button_reader.sv
// Scoreboard bench for button_reader: each scenario pushes the pulse events it
// expects and compares them against the pulses captured from the DUT.
module tb_button_reader;
    import button_reader_pkg::*;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] cyc;
        logic [7:0]  cnt;
        logic        lvl;
    } ev_t;

    localparam logic [2:0] K_PRESS = 3'b001;
    localparam logic [2:0] K_REL   = 3'b010;
    localparam logic [2:0] K_LONG  = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       level, press, rel, lng;
    logic [7:0] count;

    logic [31:0] cyc = '0;
    logic [7:0]  expCount = '0;
    ev_t         expQ[$];
    ev_t         obsQ[$];
    ev_t         e, o;
    int          nCompared = 0;
    int          nFailed = 0;

    button_reader dut (
        .clk_in1      (clk),
        .rst_in1      (rst),
        .btn_in1      (btn),
        .level_out1   (level),
        .press_out1   (press),
        .release_out1 (rel),
        .long_out1    (lng),
        .count_out1   (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every pulse with the posedge index that produced it.
    always @(negedge clk) begin
        if (!rst && (press || rel || lng))
            obsQ.push_back('{kind: {lng, rel, press}, cyc: cyc, cnt: count, lvl: level});
    end

    // Expectations assume btn changed at the negedge with cycle index c.
    task automatic pushPress(input logic [31:0] c);
        expCount = expCount + 8'd1;
        expQ.push_back('{kind: K_PRESS, cyc: c + 32'd18, cnt: expCount, lvl: 1'b1});
    endtask

    task automatic pushRelease(input logic [31:0] c);
        expQ.push_back('{kind: K_REL, cyc: c + 32'd18, cnt: expCount, lvl: 1'b0});
    endtask

    task automatic test_reset;
        rst = 1'b1;
        btn = 1'b1;
        repeat (3) @(negedge clk);
        nCompared += 5;
        if (level !== 1'b0) begin nFailed++; $display("[TB] FAIL reset_level: actual %b required 0", level); end
        if (press !== 1'b0) begin nFailed++; $display("[TB] FAIL reset_press: actual %b required 0", press); end
        if (rel   !== 1'b0) begin nFailed++; $display("[TB] FAIL reset_release: actual %b required 0", rel); end
        if (lng   !== 1'b0) begin nFailed++; $display("[TB] FAIL reset_long: actual %b required 0", lng); end
        if (count !== 8'd0) begin nFailed++; $display("[TB] FAIL reset_count: actual %0d required 0", count); end
        expCount = 8'd0;
        rst = 1'b0;
        pushPress(cyc);
        repeat (30) @(negedge clk);
        btn = 1'b0;
        pushRelease(cyc);
        repeat (30) @(negedge clk);
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            nCompared++;
            if (obsQ.size() == 0) begin
                nFailed++; $display("[TB] FAIL reset_missing: actual none required kind=%b cyc=%0d", e.kind, e.cyc);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin nFailed++; $display("[TB] FAIL reset_event: actual kind=%b cyc=%0d cnt=%0d lvl=%b required kind=%b cyc=%0d cnt=%0d lvl=%b", o.kind, o.cyc, o.cnt, o.lvl, e.kind, e.cyc, e.cnt, e.lvl); end
            end
        end
        nCompared++;
        if (obsQ.size() != 0) begin nFailed++; $display("[TB] FAIL reset_extra: actual %0d extra events required 0", obsQ.size()); obsQ.delete(); end
    endtask

    task automatic test_clean;
        btn = 1'b1;
        pushPress(cyc);
        repeat (60) @(negedge clk);
        nCompared++;
        if (level !== 1'b1) begin nFailed++; $display("[TB] FAIL clean_level_high: actual %b required 1", level); end
        repeat (40) @(negedge clk);
        btn = 1'b0;
        pushRelease(cyc);
        repeat (30) @(negedge clk);
        nCompared++;
        if (level !== 1'b0) begin nFailed++; $display("[TB] FAIL clean_level_low: actual %b required 0", level); end
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            nCompared++;
            if (obsQ.size() == 0) begin
                nFailed++; $display("[TB] FAIL clean_missing: actual none required kind=%b cyc=%0d", e.kind, e.cyc);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin nFailed++; $display("[TB] FAIL clean_event: actual kind=%b cyc=%0d cnt=%0d lvl=%b required kind=%b cyc=%0d cnt=%0d lvl=%b", o.kind, o.cyc, o.cnt, o.lvl, e.kind, e.cyc, e.cnt, e.lvl); end
            end
        end
        nCompared++;
        if (obsQ.size() != 0) begin nFailed++; $display("[TB] FAIL clean_extra: actual %0d extra events required 0", obsQ.size()); obsQ.delete(); end
    endtask

    task automatic test_bounce;
        for (int i = 0; i < 5; i++) begin
            btn = 1'b1;
            repeat (3) @(negedge clk);
            btn = 1'b0;
            repeat (2) @(negedge clk);
        end
        btn = 1'b1;
        pushPress(cyc);
        repeat (40) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            btn = 1'b0;
            repeat (2) @(negedge clk);
            btn = 1'b1;
            repeat (3) @(negedge clk);
        end
        btn = 1'b0;
        pushRelease(cyc);
        repeat (30) @(negedge clk);
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            nCompared++;
            if (obsQ.size() == 0) begin
                nFailed++; $display("[TB] FAIL bounce_missing: actual none required kind=%b cyc=%0d", e.kind, e.cyc);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin nFailed++; $display("[TB] FAIL bounce_event: actual kind=%b cyc=%0d cnt=%0d lvl=%b required kind=%b cyc=%0d cnt=%0d lvl=%b", o.kind, o.cyc, o.cnt, o.lvl, e.kind, e.cyc, e.cnt, e.lvl); end
            end
        end
        nCompared++;
        if (obsQ.size() != 0) begin nFailed++; $display("[TB] FAIL bounce_extra: actual %0d extra events required 0", obsQ.size()); obsQ.delete(); end
    endtask

    task automatic test_mid_reset;
        btn = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        rst = 1'b0;
        expCount = 8'd0;
        repeat (40) @(negedge clk);
        nCompared += 4;
        if (obsQ.size() != 0) begin nFailed++; $display("[TB] FAIL midreset_pulses: actual %0d events required 0", obsQ.size()); obsQ.delete(); end
        if (count !== 8'd0) begin nFailed++; $display("[TB] FAIL midreset_count: actual %0d required 0", count); end
        if (level !== 1'b0) begin nFailed++; $display("[TB] FAIL midreset_level: actual %b required 0", level); end
        if (dut.state_q !== IDLE) begin nFailed++; $display("[TB] FAIL midreset_state: actual %0d required %0d", dut.state_q, IDLE); end
    endtask

    task automatic test_toggle;
        for (int i = 0; i < 30; i++) begin
            btn = 1'b1;
            repeat (4) @(negedge clk);
            btn = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (30) @(negedge clk);
        nCompared += 3;
        if (obsQ.size() != 0) begin nFailed++; $display("[TB] FAIL toggle_pulses: actual %0d events required 0", obsQ.size()); obsQ.delete(); end
        if (level !== 1'b0) begin nFailed++; $display("[TB] FAIL toggle_level: actual %b required 0", level); end
        if (count !== expCount) begin nFailed++; $display("[TB] FAIL toggle_count: actual %0d required %0d", count, expCount); end
    endtask

    task automatic test_long;
        logic [31:0] c;
        btn = 1'b1;
        c = cyc;
        pushPress(c);
`ifdef BUTTON_READER_LONG_PRESS_EN
        expQ.push_back('{kind: K_LONG, cyc: c + 32'd18 + 32'd256, cnt: expCount, lvl: 1'b1});
`endif
        repeat (1000) @(negedge clk);
        btn = 1'b0;
        pushRelease(cyc);
        repeat (30) @(negedge clk);
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            nCompared++;
            if (obsQ.size() == 0) begin
                nFailed++; $display("[TB] FAIL long_missing: actual none required kind=%b cyc=%0d", e.kind, e.cyc);
            end else begin
                o = obsQ.pop_front();
                if (o !== e) begin nFailed++; $display("[TB] FAIL long_event: actual kind=%b cyc=%0d cnt=%0d lvl=%b required kind=%b cyc=%0d cnt=%0d lvl=%b", o.kind, o.cyc, o.cnt, o.lvl, e.kind, e.cyc, e.cnt, e.lvl); end
            end
        end
        nCompared++;
        if (obsQ.size() != 0) begin nFailed++; $display("[TB] FAIL long_extra: actual %0d extra events required 0", obsQ.size()); obsQ.delete(); end
    endtask

    task automatic test_wrap;
        int nPress;
        rst = 1'b1;
        btn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expCount = 8'd0;
        for (int i = 0; i < 257; i++) begin
            btn = 1'b1;
            pushPress(cyc);
            repeat (20) @(negedge clk);
            btn = 1'b0;
            pushRelease(cyc);
            repeat (20) @(negedge clk);
        end
        nPress = 0;
        while (expQ.size() != 0) begin
            e = expQ.pop_front();
            nCompared++;
            if (obsQ.size() == 0) begin
                nFailed++; $display("[TB] FAIL wrap_missing: actual none required kind=%b cyc=%0d", e.kind, e.cyc);
            end else begin
                o = obsQ.pop_front();
                if (o.kind == K_PRESS) nPress++;
                if (o !== e) begin nFailed++; $display("[TB] FAIL wrap_event: actual kind=%b cyc=%0d cnt=%0d lvl=%b required kind=%b cyc=%0d cnt=%0d lvl=%b", o.kind, o.cyc, o.cnt, o.lvl, e.kind, e.cyc, e.cnt, e.lvl); end
            end
        end
        nCompared += 3;
        if (obsQ.size() != 0) begin nFailed++; $display("[TB] FAIL wrap_extra: actual %0d extra events required 0", obsQ.size()); obsQ.delete(); end
        if (nPress != 257) begin nFailed++; $display("[TB] FAIL wrap_npress: actual %0d required 257", nPress); end
        if (count !== 8'd1) begin nFailed++; $display("[TB] FAIL wrap_count: actual %0d required 1", count); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean();
        test_bounce();
        test_mid_reset();
        test_toggle();
        test_long();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule

// File: doc/button_reader.md
Name: button_reader

Overview:
- Input-side counterpart to the LED driver blocks: samples a raw mechanical pushbutton, synchronises and debounces it, and reports clean events.
- Outputs: debounced level, one-cycle press and release pulses, an optional long-press pulse, and a wrapping press counter.
- Sits between a board pin and user logic, such as LED blink-mode selection, in the same `clk_in1` domain.

Parameters:
- DEB_CYC, 16: consecutive stable synchronised samples required to accept a level change (>=2).
- LONG_CYC, 256: cycles in PRESSED before the long-press pulse (> DEB_CYC).
- CNT_W, 8: width of the press counter.

Ports:
- clk_in1  input  1  system clock, all logic on posedge.
- rst_in1  input  1  asynchronous reset, active-high.
- btn_in1  input  1  raw button, active-high, asynchronous to `clk_in1`.
- level_out1  output  1  debounced button level.
- press_out1  output  1  one-cycle pulse on accepted press.
- release_out1  output  1  one-cycle pulse on accepted release.
- long_out1  output  1  one-cycle pulse on long press (see Optional Feature).
- count_out1  output  CNT_W  number of accepted presses, wraps.

Behaviour:
- Reset: one clock, `clk_in1`. Reset is asynchronous and active-high on `rst_in1`. While `rst_in1`=1, all outputs are 0, both synchroniser flops are 0, all internal counters are 0, and the FSM is in IDLE. Reset asserted mid-debounce or mid-press abandons the operation with no pulse.
- Synchroniser: `btn_in1` passes through 2 flops; `sync` is the second flop.
- FSM states and transitions:
  - IDLE (level 0): `sync`=1 -> PRESS_WAIT, deb_cnt=1.
  - PRESS_WAIT: `sync`=0 -> IDLE, deb_cnt=0. `sync`=1 with deb_cnt==DEB_CYC-1 -> PRESSED, registering `press_out1`=1, `level_out1`=1, `count_out1`+1. Otherwise deb_cnt+1.
  - PRESSED (level 1): `sync`=0 -> RELEASE_WAIT, deb_cnt=1. Otherwise long_cnt+1, saturating at LONG_CYC.
  - RELEASE_WAIT: `sync`=1 -> PRESSED, deb_cnt=0, long_cnt unchanged and no pulse. `sync`=0 with deb_cnt==DEB_CYC-1 -> IDLE, registering `release_out1`=1, `level_out1`=0, long_cnt=0. Otherwise deb_cnt+1.
- Press latency: with `btn_in1` held high from before posedge k, `press_out1` is high for exactly the cycle following posedge k+DEB_CYC+1. Release latency is symmetric.
- Glitches: high or low excursions lasting fewer than DEB_CYC `sync` samples produce no pulse, no level change and no count change.
- Pulses: `press_out1`, `release_out1` and `long_out1` are each high for exactly 1 cycle per event and never simultaneously.
- Counter: `count_out1` increments modulo 2^CNT_W, so 255 -> 0 at CNT_W=8. It is updated on the same edge that asserts `press_out1`.
- Button held through reset release: treated as a fresh press; it debounces normally and is counted.
- Free-running `btn_in1` toggling at period < DEB_CYC: outputs remain static.

Optional Feature:
- Macro: BUTTON_READER_LONG_PRESS_EN.
- Defined:
  - Long press: when long_cnt reaches LONG_CYC-1 in PRESSED, `long_out1` pulses once.
  - No repeat: the pulse fires at most once per press, even if the button is held indefinitely.
  - Bounce: a RELEASE_WAIT bounce back to PRESSED does not re-arm the pulse.
- Not defined: long_cnt logic is omitted; `long_out1` is tied 0; the port remains present.

Decomposition:
- Shared package `button_reader_pkg`:
  - FSM state encoding: IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3.
  - Default values of DEB_CYC and LONG_CYC.
  - Width helper constant for deb_cnt/long_cnt.
- Sub-module `sync_2ff`: two-flop synchroniser with async active-high reset to 0. It is reusable for other pin inputs.
- FSM, debounce counter, long counter and press counter stay in `button_reader`.

Test Plan:
- Reset: `rst_in1`=1 with `btn_in1`=1 -> all outputs 0. After reset release, with `btn_in1` held, `press_out1` pulses 1 cycle after posedge 17 from release and `count_out1`=1.
- Clean press/release, DEB_CYC=16: high for 100 cycles then low -> one `press_out1`, `level_out1` 1 for ~100 cycles, then one `release_out1` 18 cycles after the falling input.
- Bounce: 5 pulses of 3 cycles high / 2 low, then solid high -> exactly one `press_out1`, 18 cycles after the last rising edge, and `count_out1`=1.
- Wrap, CNT_W=8: 257 clean presses -> `count_out1`=1 and 257 `press_out1` pulses.
- Mid-debounce reset: high for 10 cycles, then `rst_in1` pulse, then low -> no pulses, `count_out1`=0, FSM IDLE.
- Long press, macro defined, LONG_CYC=256: hold 1000 cycles -> exactly one `long_out1` 256 cycles after `press_out1`. Without the macro, `long_out1` stays 0.
